// File: rtl/blink_rate_ctrl_pkg.sv
// Shared defaults and request type for the blink rate controller.
// Pure declarations; no logic.
package blink_rate_ctrl_pkg;

  localparam int RATE_W_DEF    = 4;
  localparam int SLOW_INIT_DEF = 8;
  localparam int FAST_INIT_DEF = 2;

  // One channel's rate adjust request for the current cycle.
  typedef struct packed {
    logic left;
    logic right;
  } rate_req_t;

endpackage

// File: rtl/blink_channel.sv
// One flash channel: saturating rate register, phase counter and toggling output.
// Registered outputs, rate change visible next cycle; no backpressure.
module blink_channel
  import blink_rate_ctrl_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF,
  parameter int INIT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              restart,
  input  rate_req_t         req,
  output logic              blink,
  output logic [RATE_W-1:0] rate
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] rate_nxt;

  always_comb begin
    rate_nxt = rate;
    if (req.left && !req.right && rate != '1)
      rate_nxt = rate + 1'b1;
    else if (req.right && !req.left && rate != '0)
      rate_nxt = rate - 1'b1;
  end

  // Compare against the registered rate; >= lets a lowered rate end the period early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate  <= RATE_W'(INIT);
      cnt   <= '0;
      blink <= 1'b0;
    end else begin
      rate <= rate_nxt;
      if (restart) begin
        cnt   <= '0;
        blink <= 1'b0;
      end else if (tick) begin
        if (cnt >= rate) begin
          cnt   <= '0;
          blink <= ~blink;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Shared base-tick prescaler feeding slow and fast blink channels.
// Half-period (rate+1)*BASE_DIV cycles; outputs registered; no backpressure.
module blink_rate_ctrl
  import blink_rate_ctrl_pkg::*;
#(
  parameter int BASE_DIV  = 1000000,
  parameter int RATE_W    = RATE_W_DEF,
  parameter int SLOW_INIT = SLOW_INIT_DEF,
  parameter int FAST_INIT = FAST_INIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slow_left,
  input  logic              slow_right,
  input  logic              fast_left,
  input  logic              fast_right,
  input  logic              restart,
  output logic              blink_slow,
  output logic              blink_fast,
  output logic [RATE_W-1:0] rate_slow,
  output logic [RATE_W-1:0] rate_fast
);

  localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BASE_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;
  rate_req_t     slow_req;
  rate_req_t     fast_req;

  assign tick     = (pre == PRE_LAST);
  assign slow_req = '{left: slow_left, right: slow_right};
  assign fast_req = '{left: fast_left, right: fast_right};

  // Restart re-phases the prescaler so the first toggle lands a full half-period later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pre <= '0;
    else if (restart || tick)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

  blink_channel #(.RATE_W(RATE_W), .INIT(SLOW_INIT)) u_slow (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .restart (restart),
    .req     (slow_req),
    .blink   (blink_slow),
    .rate    (rate_slow)
  );

  blink_channel #(.RATE_W(RATE_W), .INIT(FAST_INIT)) u_fast (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .restart (restart),
    .req     (fast_req),
    .blink   (blink_fast),
    .rate    (rate_fast)
  );

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl with BASE_DIV=4; toggle edges counted from restart/reset release.
module tb_blink_rate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       slow_left, slow_right, fast_left, fast_right, restart;
  logic       blink_slow, blink_fast;
  logic [3:0] rate_slow, rate_fast;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int slow_chg[$];
  int fast_chg[$];
  logic ps = 1'b0;
  logic pf = 1'b0;

  blink_rate_ctrl #(.BASE_DIV(4), .RATE_W(4), .SLOW_INIT(8), .FAST_INIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .slow_left  (slow_left),
    .slow_right (slow_right),
    .fast_left  (fast_left),
    .fast_right (fast_right),
    .restart    (restart),
    .blink_slow (blink_slow),
    .blink_fast (blink_fast),
    .rate_slow  (rate_slow),
    .rate_fast  (rate_fast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // One clock edge, sample 1 time unit later, log output transitions by edge index.
  task automatic cyc();
    @(posedge clk);
    #1;
    edge_n++;
    if (blink_slow !== ps) slow_chg.push_back(edge_n);
    if (blink_fast !== pf) fast_chg.push_back(edge_n);
    ps = blink_slow;
    pf = blink_fast;
  endtask

  task automatic clear_log();
    edge_n = 0;
    slow_chg.delete();
    fast_chg.delete();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    clear_log();
  endtask

  initial begin
    reset = 1'b0;
    slow_left = 0; slow_right = 0; fast_left = 0; fast_right = 0; restart = 0;
    repeat (3) cyc();
    check("reset_rate_slow", 32'(rate_slow), 8);
    check("reset_rate_fast", 32'(rate_fast), 2);
    check("reset_blink_slow", 32'(blink_slow), 0);
    check("reset_blink_fast", 32'(blink_fast), 0);

    // Default rates after release: fast every 12, slow every 36.
    reset = 1'b1;
    clear_log();
    repeat (40) cyc();
    check("init_fast_t0", 32'(qat(fast_chg, 0)), 12);
    check("init_fast_t1", 32'(qat(fast_chg, 1)), 24);
    check("init_fast_t2", 32'(qat(fast_chg, 2)), 36);
    check("init_slow_t0", 32'(qat(slow_chg, 0)), 36);
    check("init_slow_n", 32'(slow_chg.size()), 1);

    // Ten slow_left pulses saturate at 15.
    for (int i = 1; i <= 10; i++) begin
      slow_left = 1'b1;
      cyc();
      check($sformatf("slow_inc_%0d", i), 32'(rate_slow), (8 + i > 15) ? 15 : 8 + i);
    end
    slow_left = 1'b0;
    do_restart();
    repeat (130) cyc();
    check("slow15_t0", 32'(qat(slow_chg, 0)), 64);
    check("slow15_t1", 32'(qat(slow_chg, 1)), 128);

    // Three fast_right pulses saturate at 0, then 4-cycle half-period.
    for (int i = 1; i <= 3; i++) begin
      fast_right = 1'b1;
      cyc();
      check($sformatf("fast_dec_%0d", i), 32'(rate_fast), (i == 1) ? 1 : 0);
    end
    fast_right = 1'b0;
    do_restart();
    repeat (10) cyc();
    check("fast0_t0", 32'(qat(fast_chg, 0)), 4);
    check("fast0_t1", 32'(qat(fast_chg, 1)), 8);

    // Opposing pulses cancel; independent channels each move.
    slow_left = 1'b1; slow_right = 1'b1;
    cyc();
    slow_left = 1'b0;
    check("slow_both", 32'(rate_slow), 15);
    fast_left = 1'b1;
    cyc();
    slow_right = 1'b0; fast_left = 1'b0;
    check("mix_fast", 32'(rate_fast), 1);
    check("mix_slow", 32'(rate_slow), 14);

    // Lower rate below cnt mid-period: no wrap, toggle on next tick.
    slow_left = 1'b1;
    cyc();
    slow_left = 1'b0;
    check("slow_back15", 32'(rate_slow), 15);
    do_restart();
    repeat (40) cyc();
    for (int i = 0; i < 12; i++) begin
      slow_right = 1'b1;
      cyc();
    end
    slow_right = 1'b0;
    check("slow_drop3", 32'(rate_slow), 3);
    repeat (40) cyc();
    check("drop_n", 32'(slow_chg.size()), 3);
    check("drop_t0", 32'(qat(slow_chg, 0)), 48);
    check("drop_t1", 32'(qat(slow_chg, 1)), 64);
    check("drop_t2", 32'(qat(slow_chg, 2)), 80);

    // Restart with blink_fast high mid-period.
    fast_left = 1'b1;
    cyc();
    fast_left = 1'b0;
    check("fast_back2", 32'(rate_fast), 2);
    do_restart();
    repeat (16) cyc();
    check("pre_restart_fast", 32'(blink_fast), 1);
    do_restart();
    check("restart_clears", 32'(blink_fast), 0);
    repeat (14) cyc();
    check("restart_first_t", 32'(qat(fast_chg, 0)), 12);
    check("pre_reset_fast", 32'(blink_fast), 1);

    // Async reset between edges.
    #2 reset = 1'b0;
    #1;
    check("areset_rate_slow", 32'(rate_slow), 8);
    check("areset_rate_fast", 32'(rate_fast), 2);
    check("areset_blink_slow", 32'(blink_slow), 0);
    check("areset_blink_fast", 32'(blink_fast), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
